// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared RV32I load/store encodings and memory-stage FSM states
package riscv_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_REQ  = 2'b01,
    ST_WAIT = 2'b10,
    ST_DONE = 2'b11
  } mem_state_t;

  // Access size code: 00 byte, 01 half, 10 word; undefined funct3 behaves as word.
  function automatic logic [1:0] f3_size(input logic [2:0] f3);
    case (f3)
      F3_B, F3_BU: f3_size = 2'b00;
      F3_H, F3_HU: f3_size = 2'b01;
      F3_W:        f3_size = 2'b10;
      default:     f3_size = 2'b10;
    endcase
  endfunction

  function automatic logic f3_signed(input logic [2:0] f3);
    f3_signed = (f3 == F3_B) || (f3 == F3_H);
  endfunction

endpackage

// File: rtl/lsu_align.sv
// rtl/lsu_align.sv - store lane/byte-enable generation, load extraction and misalignment detect
module lsu_align
  import riscv_pkg::*;
(
  input  logic [2:0]  st_funct3,
  input  logic [1:0]  st_off,
  input  logic        st_load,
  input  logic [31:0] wdata,
  output logic [3:0]  be,
  output logic [31:0] wdata_rep,
  output logic        misaligned,
  input  logic [2:0]  ld_funct3,
  input  logic [1:0]  ld_off,
  input  logic [31:0] rdata,
  output logic [31:0] rdata_ext
);

  logic [1:0]  st_size;
  logic [1:0]  ld_size;
  logic        ld_sgn;
  logic [31:0] shifted;

  always_comb begin
    st_size    = f3_size(st_funct3);
    misaligned = ((st_size == 2'b01) && st_off[0]) ||
                 ((st_size == 2'b10) && (st_off != 2'b00));
    be         = 4'b1111;
    wdata_rep  = wdata;
    if (!st_load) begin
      case (st_size)
        2'b00: begin
          be        = 4'b0001 << st_off;
          wdata_rep = {4{wdata[7:0]}};
        end
        2'b01: begin
          be        = st_off[1] ? 4'b1100 : 4'b0011;
          wdata_rep = {2{wdata[15:0]}};
        end
        default: begin
          be        = 4'b1111;
          wdata_rep = wdata;
        end
      endcase
    end
  end

  always_comb begin
    ld_size = f3_size(ld_funct3);
    ld_sgn  = f3_signed(ld_funct3);
    shifted = rdata >> {ld_off, 3'b000};
    case (ld_size)
      2'b00:   rdata_ext = {{24{ld_sgn & shifted[7]}}, shifted[7:0]};
      2'b01:   rdata_ext = {{16{ld_sgn & shifted[15]}}, shifted[15:0]};
      default: rdata_ext = rdata;
    endcase
  end

endmodule

// File: rtl/mem_stage_ctrl.sv
// rtl/mem_stage_ctrl.sv - ME-stage load/store sequencer driving a req/gnt/rvalid data port
module mem_stage_ctrl
  import riscv_pkg::*;
#(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_rd_M,
  input  logic        mem_wr_M,
  input  logic [2:0]  funct3_M,
  input  logic [31:0] addr_M,
  input  logic [31:0] wdata_M,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_gnt,
  input  logic        dmem_rvalid,
  input  logic [31:0] dmem_rdata,
  output logic [31:0] Rdata_ext_M,
  output logic        stall_pipe,
  output logic        stall_W,
  output logic        kill_W,
  output logic        mem_err
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  mem_state_t        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              err_q, err_d;
  logic              ld_q, ld_d;
  logic [2:0]        f3_q, f3_d;
  logic [1:0]        off_q, off_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              req_q, req_d;
  logic              we_q, we_d;
  logic [31:0]       addr_q, addr_d;
  logic [3:0]        be_q, be_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              stall_c;

  logic [3:0]        st_be;
  logic [31:0]       st_wdata;
  logic              misaligned;
  logic [31:0]       ld_ext;

  lsu_align u_align (
    .st_funct3 (funct3_M),
    .st_off    (addr_M[1:0]),
    .st_load   (mem_rd_M),
    .wdata     (wdata_M),
    .be        (st_be),
    .wdata_rep (st_wdata),
    .misaligned(misaligned),
    .ld_funct3 (f3_q),
    .ld_off    (off_q),
    .rdata     (dmem_rdata),
    .rdata_ext (ld_ext)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    ld_d    = ld_q;
    f3_d    = f3_q;
    off_d   = off_q;
    rdata_d = rdata_q;
    req_d   = req_q;
    we_d    = we_q;
    addr_d  = addr_q;
    be_d    = be_q;
    wdata_d = wdata_q;
    stall_c = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (mem_rd_M || mem_wr_M) begin
          stall_c = 1'b1;
          ld_d    = mem_rd_M;
          f3_d    = funct3_M;
          off_d   = addr_M[1:0];
          if (misaligned) begin
            err_d   = 1'b1;
            state_d = ST_DONE;
          end else begin
            req_d   = 1'b1;
            we_d    = ~mem_rd_M;
            addr_d  = {addr_M[31:2], 2'b00};
            be_d    = st_be;
            wdata_d = st_wdata;
            cnt_d   = '0;
            state_d = ST_REQ;
          end
        end
      end
      ST_REQ: begin
        stall_c = 1'b1;
        cnt_d   = cnt_q + CNT_W'(1);
        if (dmem_gnt) begin
          req_d   = 1'b0;
          state_d = ld_q ? ST_WAIT : ST_DONE;
        end else if (cnt_q >= CNT_LAST) begin
          req_d   = 1'b0;
          err_d   = 1'b1;
          state_d = ST_DONE;
        end
      end
      ST_WAIT: begin
        stall_c = 1'b1;
        cnt_d   = cnt_q + CNT_W'(1);
        if (dmem_rvalid) begin
          rdata_d = ld_ext;
          state_d = ST_DONE;
        end else if (cnt_q >= CNT_LAST) begin
          err_d   = 1'b1;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        err_d   = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      ld_q    <= 1'b0;
      f3_q    <= 3'b000;
      off_q   <= 2'b00;
      rdata_q <= 32'h0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= 32'h0;
      be_q    <= 4'h0;
      wdata_q <= 32'h0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      ld_q    <= ld_d;
      f3_q    <= f3_d;
      off_q   <= off_d;
      rdata_q <= rdata_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
    end
  end

  // Stalls are forced low while reset is held so the pipeline is released immediately.
  assign stall_pipe  = rst_n & stall_c;
  assign stall_W     = rst_n & stall_c;
  assign mem_err     = (state_q == ST_DONE) && err_q;
  assign kill_W      = (state_q == ST_DONE) && err_q;
  assign Rdata_ext_M = err_q ? 32'h0 : rdata_q;
  assign dmem_req    = req_q;
  assign dmem_we     = we_q;
  assign dmem_addr   = addr_q;
  assign dmem_be     = be_q;
  assign dmem_wdata  = wdata_q;

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// tb/tb_mem_stage_ctrl.sv - self-checking bench for mem_stage_ctrl
module tb_mem_stage_ctrl;

  localparam int T = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        mem_rd_M = 1'b0, mem_wr_M = 1'b0;
  logic [2:0]  funct3_M = 3'b000;
  logic [31:0] addr_M = 32'h0, wdata_M = 32'h0;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata;
  logic [3:0]  dmem_be;
  logic        dmem_gnt = 1'b0, dmem_rvalid = 1'b0;
  logic [31:0] dmem_rdata = 32'h0;
  logic [31:0] Rdata_ext_M;
  logic        stall_pipe, stall_W, kill_W, mem_err;

  mem_stage_ctrl #(.TIMEOUT(T), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .mem_rd_M(mem_rd_M), .mem_wr_M(mem_wr_M), .funct3_M(funct3_M),
    .addr_M(addr_M), .wdata_M(wdata_M),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_be(dmem_be), .dmem_wdata(dmem_wdata),
    .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
    .Rdata_ext_M(Rdata_ext_M), .stall_pipe(stall_pipe), .stall_W(stall_W),
    .kill_W(kill_W), .mem_err(mem_err)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int fails   = 0;

  // Expected values for the current cycle, set by the stimulus a moment after each rising edge.
  logic        e_en = 1'b0;
  logic        e_stall = 1'b0, e_req = 1'b0, e_err = 1'b0;
  logic        e_bus = 1'b0, e_we = 1'b0, e_st = 1'b0, e_chk_rd = 1'b0;
  logic [31:0] e_addr = 32'h0, e_wd = 32'h0, e_rd = 32'h0;
  logic [3:0]  e_be = 4'h0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (e_en) begin
      chk("stall_pipe", 32'(stall_pipe), 32'(e_stall));
      chk("stall_W", 32'(stall_W), 32'(e_stall));
      chk("dmem_req", 32'(dmem_req), 32'(e_req));
      chk("mem_err", 32'(mem_err), 32'(e_err));
      chk("kill_W", 32'(kill_W), 32'(e_err));
      if (e_bus) begin
        chk("dmem_we", 32'(dmem_we), 32'(e_we));
        chk("dmem_addr", dmem_addr, e_addr);
        chk("dmem_be", 32'(dmem_be), 32'(e_be));
        if (e_st) chk("dmem_wdata", dmem_wdata, e_wd);
      end
      if (e_chk_rd) chk("Rdata_ext_M", Rdata_ext_M, e_rd);
    end
  end

  task automatic set_exp(input logic st, input logic rq, input logic er);
    e_stall = st;
    e_req   = rq;
    e_err   = er;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    set_exp(1'b0, 1'b0, 1'b0);
    e_bus = 1'b0;
    e_chk_rd = 1'b0;
    for (int i = 0; i < n; i++) tick();
  endtask

  // One ME instruction; g = REQ cycle carrying gnt, v = WAIT cycle carrying rvalid (-1 = never).
  task automatic run_op(input logic rd, input logic wr, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wd,
                        input int g, input int v, input logic [31:0] rdata,
                        input logic [31:0] lit, input bit lit_en);
    int          size, off, budget;
    bit          mis, ld, granted, hit, err;
    logic [3:0]  be;
    logic [31:0] wrep, sh, ldv;
    ld   = rd;
    size = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
    off  = int'(addr[1:0]);
    mis  = (off % size) != 0;
    be   = ld ? 4'hF : 4'(((1 << size) - 1) << off);
    for (int i = 0; i < 4; i++) wrep[8*i +: 8] = wd[8*(i % size) +: 8];
    sh = rdata >> (8 * off);
    if (size == 4)      ldv = rdata;
    else if (size == 2) ldv = f3[2] ? {16'h0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
    else                ldv = f3[2] ? {24'h0, sh[7:0]}  : {{24{sh[7]}}, sh[7:0]};

    mem_rd_M = rd; mem_wr_M = wr; funct3_M = f3; addr_M = addr; wdata_M = wd;
    set_exp(1'b1, 1'b0, 1'b0);
    e_bus = 1'b0;
    e_chk_rd = 1'b0;
    tick();
    granted = 0;
    hit = 0;
    if (!mis) begin
      e_bus = 1'b1; e_we = !ld; e_st = !ld;
      e_addr = {addr[31:2], 2'b00}; e_be = be; e_wd = wrep;
      for (int i = 0; i < T; i++) begin
        set_exp(1'b1, 1'b1, 1'b0);
        dmem_gnt = (i == g);
        tick();
        dmem_gnt = 1'b0;
        if (i == g) begin
          granted = 1;
          break;
        end
      end
      e_bus = 1'b0;
      if (ld && granted) begin
        budget = (T - (g + 1) > 0) ? T - (g + 1) : 1;
        for (int j = 0; j < budget; j++) begin
          set_exp(1'b1, 1'b0, 1'b0);
          dmem_rvalid = (j == v);
          dmem_rdata  = (j == v) ? rdata : 32'h5A5A_0F0F;
          tick();
          dmem_rvalid = 1'b0;
          if (j == v) begin
            hit = 1;
            break;
          end
        end
      end
    end
    err = mis || !granted || (ld && !hit);
    set_exp(1'b0, 1'b0, err);
    e_chk_rd = ld;
    e_rd = err ? 32'h0 : ldv;
    @(negedge clk);
    if (lit_en) chk("literal_rdata", Rdata_ext_M, lit);
    @(posedge clk);
    #1;
    mem_rd_M = 1'b0;
    mem_wr_M = 1'b0;
    set_exp(1'b0, 1'b0, 1'b0);
    e_chk_rd = 1'b0;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req", 32'(dmem_req), 32'h0);
    chk("rst_we", 32'(dmem_we), 32'h0);
    chk("rst_addr", dmem_addr, 32'h0);
    chk("rst_be", 32'(dmem_be), 32'h0);
    chk("rst_wdata", dmem_wdata, 32'h0);
    chk("rst_rdata", Rdata_ext_M, 32'h0);
    chk("rst_stall", 32'(stall_pipe), 32'h0);
    chk("rst_err", 32'(mem_err), 32'h0);
    rst_n = 1'b1;
    e_en = 1'b1;
    idle(2);

    run_op(1, 0, 3'b010, 32'h100, 32'h0, 0, 0, 32'hDEADBEEF, 32'hDEADBEEF, 1);
    run_op(1, 0, 3'b000, 32'h103, 32'h0, 0, 0, 32'h8012_3456, 32'hFFFFFF80, 1);
    run_op(1, 0, 3'b100, 32'h103, 32'h0, 0, 0, 32'h8012_3456, 32'h00000080, 1);
    run_op(1, 0, 3'b101, 32'h102, 32'h0, 0, 0, 32'hBEEF_0000, 32'h0000BEEF, 1);
    run_op(1, 0, 3'b001, 32'h102, 32'h0, 1, 2, 32'h8001_0000, 32'hFFFF8001, 1);
    idle(1);
    run_op(0, 1, 3'b000, 32'h201, 32'h0000_00A5, 0, -1, 32'h0, 32'h0, 0);
    chk("sb_be_literal", 32'(dmem_be), 32'h2);
    chk("sb_wdata_literal", dmem_wdata, 32'hA5A5A5A5);
    chk("sb_we_literal", 32'(dmem_we), 32'h1);
    run_op(0, 1, 3'b001, 32'h202, 32'h1234_ABCD, 2, -1, 32'h0, 32'h0, 0);
    chk("sh_be_literal", 32'(dmem_be), 32'hC);
    chk("sh_wdata_literal", dmem_wdata, 32'hABCDABCD);
    run_op(0, 1, 3'b010, 32'h202, 32'h1111_2222, 0, -1, 32'h0, 32'h0, 0);
    run_op(1, 0, 3'b001, 32'h101, 32'h0, 0, 0, 32'h1234_5678, 32'h0, 1);
    run_op(1, 0, 3'b010, 32'h300, 32'h0, -1, -1, 32'h0, 32'h0, 1);
    run_op(1, 0, 3'b010, 32'h304, 32'h0, 0, 0, 32'hCAFE_F00D, 32'hCAFEF00D, 1);
    run_op(1, 0, 3'b010, 32'h308, 32'h0, 2, -1, 32'h0, 32'h0, 1);
    run_op(0, 1, 3'b010, 32'h400, 32'h7654_3210, 0, -1, 32'h0, 32'h0, 0);
    run_op(1, 0, 3'b010, 32'h404, 32'h0, 1, 3, 32'h0BAD_CAFE, 32'h0BADCAFE, 1);
    run_op(1, 1, 3'b010, 32'h408, 32'hFFFF_FFFF, 0, 0, 32'h1357_9BDF, 32'h13579BDF, 1);
    run_op(1, 0, 3'b011, 32'h40C, 32'h0, 0, 1, 32'h8765_4321, 32'h87654321, 1);
    run_op(1, 0, 3'b110, 32'h410, 32'h0, 0, 0, 32'hF000_000F, 32'hF000000F, 1);

    // Reset asserted while a load waits for rvalid.
    mem_rd_M = 1'b1; funct3_M = 3'b010; addr_M = 32'h500;
    set_exp(1'b1, 1'b0, 1'b0);
    tick();
    set_exp(1'b1, 1'b1, 1'b0);
    dmem_gnt = 1'b1;
    tick();
    dmem_gnt = 1'b0;
    set_exp(1'b1, 1'b0, 1'b0);
    @(negedge clk);
    #1;
    e_en = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("reset_wait_req", 32'(dmem_req), 32'h0);
    chk("reset_wait_stall", 32'(stall_pipe), 32'h0);
    chk("reset_wait_stall_W", 32'(stall_W), 32'h0);
    dmem_rvalid = 1'b1;
    dmem_rdata = 32'h1234_5678;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    mem_rd_M = 1'b0;
    e_en = 1'b1;
    idle(1);
    dmem_rvalid = 1'b0;
    idle(1);
    chk("late_rvalid_ignored", Rdata_ext_M, 32'h0);
    run_op(1, 0, 3'b010, 32'h500, 32'h0, 0, 0, 32'h2468_ACE0, 32'h2468ACE0, 1);
    idle(2);
    e_en = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
